// File: rtl/seq_sqrt_pkg.sv
// Shared definitions for the square-root datapath (seq_sqrt) and its
// inverse-square-root neighbours.
//   - state_t       : control state of the iterative root unit
//   - SQRT_*        : default radicand/root formats (3.8 in, 2.5 out)
//   - rad_shift()   : left shift that aligns the radicand binary point with
//                     twice the root's fractional bits
package seq_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SQRT_IN_W     = 11;
  localparam int SQRT_IN_FRAC  = 8;
  localparam int SQRT_OUT_W    = 7;
  localparam int SQRT_OUT_FRAC = 5;

  function automatic int rad_shift(input int out_frac, input int in_frac);
    return 2 * out_frac - in_frac;
  endfunction

  localparam int SQRT_RAD_SHIFT = rad_shift(SQRT_OUT_FRAC, SQRT_IN_FRAC);

endpackage

// File: rtl/seq_sqrt_step.sv
// One restoring digit-recurrence square-root iteration (combinational).
// Ports:
//   rem_i  [OUT_W+1:0] : partial remainder
//   root_i [OUT_W-1:0] : partial root
//   bits_i [1:0]       : next two radicand bits, MSB first
//   rem_o, root_o      : updated remainder / root
module seq_sqrt_step #(
  parameter int OUT_W = 7
) (
  input  logic [OUT_W+1:0] rem_i,
  input  logic [OUT_W-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [OUT_W+1:0] rem_o,
  output logic [OUT_W-1:0] root_o
);

  localparam int RW = OUT_W + 2;

  // Shifted remainder and trial are kept two bits wider than the stored
  // remainder so the compare never wraps; the result always fits in RW bits.
  logic [RW+1:0] rem_sh;
  logic [RW+1:0] trial;
  logic          ge;

  assign rem_sh = {rem_i, bits_i};
  assign trial  = {2'b00, root_i, 2'b01};
  assign ge     = (rem_sh >= trial);

  assign rem_o  = ge ? RW'(rem_sh - trial) : RW'(rem_sh);
  assign root_o = OUT_W'({root_i, ge});

endmodule

// File: rtl/seq_sqrt.sv
// Iterative square root: unsigned 3.8 radicand in, floor root as unsigned
// 2.5 out, one root bit per clock, valid/ready on both sides.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : radicand handshake, in_data sampled on accept
//   out_valid/out_ready : result handshake, result held until taken
//   out_root            : floor(sqrt(in_data)), OUT_W bits
//   out_exact           : final remainder is zero
module seq_sqrt
  import seq_sqrt_pkg::*;
#(
  parameter int IN_W     = SQRT_IN_W,
  parameter int IN_FRAC  = SQRT_IN_FRAC,
  parameter int OUT_W    = SQRT_OUT_W,
  parameter int OUT_FRAC = SQRT_OUT_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_root,
  output logic             out_exact
);

  localparam int SHIFT = rad_shift(OUT_FRAC, IN_FRAC);
  localparam int RADW  = 2 * OUT_W;
  localparam int RW    = OUT_W + 2;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  if (2 * OUT_FRAC < IN_FRAC) begin : g_bad_frac
    $error("seq_sqrt: 2*OUT_FRAC must be >= IN_FRAC");
  end
  if (IN_W + SHIFT > RADW) begin : g_bad_width
    $error("seq_sqrt: scaled radicand does not fit in 2*OUT_W bits");
  end

  state_t           state_q, state_d;
  logic [RADW-1:0]  rad_q, rad_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [RADW-1:0]  rad_in;
  logic [RW-1:0]    step_rem;
  logic [OUT_W-1:0] step_root;
  logic             accept;

  assign rad_in = RADW'(in_data) << SHIFT;

  seq_sqrt_step #(
    .OUT_W (OUT_W)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[RADW-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          rad_d   = rad_in;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(OUT_W - 1);
        end
      end
      CALC: begin
        // Radicand is consumed two bits per cycle from the top.
        rad_d  = rad_q << 2;
        rem_d  = step_rem;
        root_d = step_root;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // Result leaves and the next radicand enters on the same edge.
            state_d = CALC;
            rad_d   = rad_in;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = CW'(OUT_W - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_root  = root_q;
  // Gated by DONE so the cleared remainder after reset does not read as exact.
  assign out_exact = (state_q == DONE) && (rem_q == '0);

endmodule

// File: tb/tb_seq_sqrt.sv
module tb_seq_sqrt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  out_root;
  logic        out_exact;

  int nvec = 0;
  int nerr = 0;

  seq_sqrt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_root  (out_root),
    .out_exact (out_exact)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: floor(sqrt(d * 4)) by plain integer search.
  function automatic int model_root(input int d);
    int v;
    int r;
    v = d * 4;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic model_exact(input int d);
    int r;
    r = model_root(d);
    return (r * r == d * 4);
  endfunction

  task automatic start_txn(input logic [10:0] d);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    @(posedge clk);
  endtask

  // Called just after the accept edge; lat = edges from accept to out_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (out_valid === 1'b1) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    nvec++; if (out_root !== 7'd0) begin nerr++; $display("FAIL rst_out_root got=%0d want=0", out_root); end
    nvec++; if (out_exact !== 1'b0) begin nerr++; $display("FAIL rst_out_exact got=%b want=0", out_exact); end
    rst_n = 1'b1;
    @(negedge clk);
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [10:0] din  [6] = '{11'd1024, 11'd256, 11'd64, 11'd512, 11'd2047, 11'd0};
    logic [6:0]  rexp [6] = '{7'd64, 7'd32, 7'd16, 7'd45, 7'd90, 7'd0};
    logic        eexp [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_txn(din[i]);
      wait_result(lat);
      nvec++; if (lat !== 7) begin nerr++; $display("FAIL dir_latency in=%0d got=%0d want=7", din[i], lat); end
      nvec++; if (out_root !== rexp[i]) begin nerr++; $display("FAIL dir_root in=%0d got=%0d want=%0d", din[i], out_root, rexp[i]); end
      nvec++; if (out_exact !== eexp[i]) begin nerr++; $display("FAIL dir_exact in=%0d got=%b want=%b", din[i], out_exact, eexp[i]); end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int er;
    er = model_root(700);
    start_txn(11'd700);
    wait_result(lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_hold_valid k=%0d got=%b want=1", k, out_valid); end
      nvec++; if (out_root !== 7'(er)) begin nerr++; $display("FAIL bp_hold_root k=%0d got=%0d want=%0d", k, out_root, er); end
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_hold_in_ready k=%0d got=%b want=0", k, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 11'd1024;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_same_cycle_ready got=%b want=1", in_ready); end
    @(posedge clk);
    wait_result(lat);
    nvec++; if (lat !== 7) begin nerr++; $display("FAIL bp_second_latency got=%0d want=7", lat); end
    nvec++; if (out_root !== 7'd64) begin nerr++; $display("FAIL bp_second_root got=%0d want=64", out_root); end
    nvec++; if (out_exact !== 1'b1) begin nerr++; $display("FAIL bp_second_exact got=%b want=1", out_exact); end
    release_result();
  endtask

  task automatic test_reset_mid();
    int  lat;
    logic seen;
    // Reset three iterations into a calculation.
    start_txn(11'd2047);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    nvec++; if (out_root !== 7'd0) begin nerr++; $display("FAIL midrst_root got=%0d want=0", out_root); end
    nvec++; if (out_exact !== 1'b0) begin nerr++; $display("FAIL midrst_exact got=%b want=0", out_exact); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    seen = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL midrst_spurious_valid got=%b want=0", seen); end
    start_txn(11'd1024);
    wait_result(lat);
    nvec++; if (lat !== 7 || out_root !== 7'd64) begin nerr++; $display("FAIL midrst_next lat=%0d root=%0d want lat=7 root=64", lat, out_root); end
    // Reset while a finished result is stalled by the consumer.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0 || out_root !== 7'd0) begin nerr++; $display("FAIL donerst valid=%b root=%0d want 0/0", out_valid, out_root); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL donerst_spurious_valid got=%b want=0", seen); end
  endtask

  task automatic test_sweep();
    int   perm [2048];
    int   q_root [$];
    logic q_ex [$];
    int   idx;
    int   got;
    int   cyc;
    int   er;
    logic ee;
    int   tmp;
    int   j;
    for (int i = 0; i < 2048; i++) perm[i] = i;
    for (int i = 2047; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    idx = 0;
    got = 0;
    cyc = 0;
    while (got < 2048 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (idx < 2048) && ($urandom_range(3, 0) != 0);
      in_data   = (idx < 2048) ? 11'(perm[idx]) : 11'd0;
      out_ready = ($urandom_range(1, 0) == 1);
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        nvec++;
        if (q_root.size() == 0) begin
          nerr++;
          $display("FAIL sweep_extra_result root=%0d with no outstanding radicand", out_root);
        end else begin
          er = q_root.pop_front();
          ee = q_ex.pop_front();
          got++;
          if (out_root !== 7'(er) || out_exact !== ee) begin
            nerr++;
            $display("FAIL sweep_result got root=%0d exact=%b want root=%0d exact=%b", out_root, out_exact, er, ee);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        q_root.push_back(model_root(perm[idx]));
        q_ex.push_back(model_exact(perm[idx]));
        idx++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    nvec++;
    if (got != 2048 || q_root.size() != 0) begin
      nerr++;
      $display("FAIL sweep_count got=%0d results pending=%0d want 2048 results 0 pending", got, q_root.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
